trdb_filter_ranges: RTL and testbench
=====================================

# trdb_filter_ranges

Parametrised instruction-trace qualifier between the retirement interface and the packet generator. Evaluates each retired instruction against NRANGES programmable address comparators, each usable as an include range, a start trigger or a stop trigger, plus an optional privilege match. Produces a registered qualify strobe and a saturating count of qualified instructions. A start/stop window FSM lets tracing begin and end on code addresses rather than on software writes.

## Interface
- NRANGES, 4, number of address comparators (1..16)
- XLEN, 32, address width; matches trdb_pkg XLEN
- CNT_W, 32, width of the qualified-instruction counter
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- ivalid_i  in  1  instruction retired this cycle
- iaddr_i  in  XLEN  retired instruction address
- priv_i  in  2  privilege mode of the retired instruction
- trace_activated_i  in  1  user master enable
- apply_filters_i  in  1  0 = qualify every valid instruction while activated
- trace_selected_priv_i  in  1  enable privilege match
- which_priv_i  in  2  privilege mode to trace
- range_mode_i  in  NRANGES×2  per comparator: 00 off, 01 include, 10 start, 11 stop
- range_lower_i  in  NRANGES×XLEN  inclusive lower bound
- range_higher_i  in  NRANGES×XLEN  exclusive upper bound
- count_clear_i  in  1  clear qualified counter
- trace_qualified_o  out  1  registered: previous-cycle instruction is qualified
- window_active_o  out  1  FSM in ACTIVE
- qual_count_o  out  CNT_W  saturating count of qualified instructions

## Operation
- hit[k] = (range_lower_i[k] <= iaddr_i) && (iaddr_i < range_higher_i[k]), unsigned. lower >= higher never hits. The mode gates whether a hit matters.
- include_ok = 1 if no comparator is in mode 01; otherwise it is the OR of hits on the mode-01 comparators.
- start_hit and stop_hit = OR of hits on comparators in mode 10 and mode 11, respectively.
- priv_ok = !trace_selected_priv_i || (priv_i == which_priv_i).
- Window FSM, states WAIT and ACTIVE. It advances only when ivalid_i && trace_activated_i && apply_filters_i.
  - WAIT → ACTIVE on start_hit && !stop_hit.
  - ACTIVE → WAIT on stop_hit. Stop wins over a simultaneous start.
  - Start and stop hit together in WAIT: stay in WAIT.
- window_ok:
  - 1 if no comparator is in mode 10.
  - Otherwise (state == ACTIVE) || start_hit.
  - Start and stop instructions are both qualified (inclusive window). A one-shot start+stop instruction in WAIT is qualified.
- qual = ivalid_i && trace_activated_i && (!apply_filters_i || (include_ok && window_ok && priv_ok)).
- trace_activated_i == 0 forces the FSM to WAIT on the next edge.
- Counter update, with clear taking priority:
  - count_clear_i → 0.
  - Else if qual and count != all-ones → count+1.
  - Else hold. The counter saturates; it does not wrap.
- Configuration inputs are sampled every cycle with no shadowing. Software changes them only while trace_activated_i == 0.

## Timing
- Reset: trace_qualified_o = 0, window_active_o = 0, qual_count_o = 0, FSM = WAIT.
- Reset in mid-operation behaves the same: FSM returns to WAIT and the counter is lost on that edge.
- trace_qualified_o and qual_count_o reflect the instruction presented in cycle N starting in cycle N+1 (latency 1). Throughput is one instruction per cycle; there is no backpressure.
- window_active_o updates on the edge after a trigger instruction.
- A back-to-back stop then start in consecutive cycles re-enters ACTIVE with no gap cycle.
- ivalid_i == 0: trace_qualified_o goes to 0 next cycle, and the FSM and counter hold.

## Structure
- trdb_pkg holds XLEN, typedef enum logic [1:0] filter_mode_e {FMODE_OFF, FMODE_INCLUDE, FMODE_START, FMODE_STOP} and typedef enum logic {WIN_WAIT, WIN_ACTIVE} win_state_e.
- Sub-module trdb_range_cmp (one comparator: lower, higher, addr → hit) is instantiated NRANGES times via generate.
- Mode decode, FSM, qual register and counter are in the top module.

## Test plan
- Reset, then apply_filters_i=0, activated=1, 5 valid instructions → trace_qualified_o high for 5 cycles starting 1 cycle later; qual_count_o=5.
- Range0 include [0x1000,0x2000), addresses 0x0FFC, 0x1000, 0x1FFC, 0x2000 → qualified 0,1,1,0; lower=higher=0x1000 → never qualified.
- Range1 start [0x100,0x104), range2 stop [0x200,0x204), sequence 0x80, 0x100, 0x180, 0x200, 0x280 → qualified 0,1,1,1,0; window_active_o high after 0x100 until after 0x200.
- Start and stop both covering 0x300 in WAIT → that instruction qualified, FSM stays WAIT; the same address while ACTIVE → qualified, FSM → WAIT.
- trace_selected_priv_i=1, which_priv_i=3, priv_i alternating 0/3 → only priv 3 qualified. Deasserting trace_activated_i while ACTIVE → WAIT next edge.
- CNT_W=4, 20 qualified instructions → count saturates at 15. count_clear_i with a qualified instruction in the same cycle → 0. rst_i mid-window → all outputs 0 next cycle.

Source files
------------

// File: rtl/trdb_pkg.sv
// Shared types for the trace debug qualifier: address width, comparator modes, window states.
package trdb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PRIV_W = 2;

  typedef enum logic [1:0] {
    FMODE_OFF     = 2'b00,
    FMODE_INCLUDE = 2'b01,
    FMODE_START   = 2'b10,
    FMODE_STOP    = 2'b11
  } filter_mode_e;

  typedef enum logic {
    WIN_WAIT   = 1'b0,
    WIN_ACTIVE = 1'b1
  } win_state_e;

endpackage

// File: rtl/trdb_filter_ranges_if.sv
// Retirement bus: one retired instruction per cycle, no backpressure.
interface trdb_filter_ranges_if #(
  parameter int unsigned XLEN = trdb_pkg::XLEN
);
  logic                          ivalid;
  logic [XLEN-1:0]               iaddr;
  logic [trdb_pkg::PRIV_W-1:0]   priv;

  modport master (output ivalid, output iaddr, output priv);
  modport slave  (input  ivalid, input  iaddr, input  priv);
endinterface

// File: rtl/trdb_range_cmp.sv
// One address comparator: hit when lower <= addr < higher (unsigned); empty ranges never hit.
module trdb_range_cmp #(
  parameter int unsigned XLEN = trdb_pkg::XLEN
) (
  input  logic [XLEN-1:0] lower_i,
  input  logic [XLEN-1:0] higher_i,
  input  logic [XLEN-1:0] addr_i,
  output logic            hit_c
);
  assign hit_c = (lower_i <= addr_i) && (addr_i < higher_i);
endmodule

// File: rtl/trdb_filter_ranges.sv
// Instruction-trace qualifier: range/priv filtering, start/stop window FSM,
// registered qualify strobe and saturating qualified-instruction counter.
module trdb_filter_ranges
  import trdb_pkg::*;
#(
  parameter int unsigned NRANGES = 4,
  parameter int unsigned XLEN    = trdb_pkg::XLEN,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  trdb_filter_ranges_if.slave              ret_if,
  input  logic                             trace_activated_i,
  input  logic                             apply_filters_i,
  input  logic                             trace_selected_priv_i,
  input  logic [PRIV_W-1:0]                which_priv_i,
  input  logic [NRANGES-1:0][1:0]          range_mode_i,
  input  logic [NRANGES-1:0][XLEN-1:0]     range_lower_i,
  input  logic [NRANGES-1:0][XLEN-1:0]     range_higher_i,
  input  logic                             count_clear_i,
  output logic                             trace_qualified_o,
  output logic                             window_active_o,
  output logic [CNT_W-1:0]                 qual_count_o
);

  logic [NRANGES-1:0] hit;

  for (genvar k = 0; k < NRANGES; k++) begin : g_cmp
    trdb_range_cmp #(.XLEN(XLEN)) u_cmp (
      .lower_i  (range_lower_i[k]),
      .higher_i (range_higher_i[k]),
      .addr_i   (ret_if.iaddr),
      .hit_c    (hit[k])
    );
  end

  win_state_e       state_q, state_d;
  logic             qual_q, qual_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic include_any, include_hit, start_any, start_hit, stop_hit;
  logic priv_ok, window_ok, include_ok, advance;

  // Gate comparator hits by their programmed role.
  always_comb begin
    include_any = 1'b0;
    include_hit = 1'b0;
    start_any   = 1'b0;
    start_hit   = 1'b0;
    stop_hit    = 1'b0;
    for (int k = 0; k < int'(NRANGES); k++) begin
      case (filter_mode_e'(range_mode_i[k]))
        FMODE_INCLUDE: begin
          include_any = 1'b1;
          include_hit = include_hit | hit[k];
        end
        FMODE_START: begin
          start_any = 1'b1;
          start_hit = start_hit | hit[k];
        end
        FMODE_STOP:  stop_hit = stop_hit | hit[k];
        default:     ;
      endcase
    end
  end

  // Qualification, window FSM next state and counter next value.
  always_comb begin
    include_ok = !include_any || include_hit;
    window_ok  = !start_any || (state_q == WIN_ACTIVE) || start_hit;
    priv_ok    = !trace_selected_priv_i || (ret_if.priv == which_priv_i);
    advance    = ret_if.ivalid && trace_activated_i && apply_filters_i;

    qual_d = ret_if.ivalid && trace_activated_i &&
             (!apply_filters_i || (include_ok && window_ok && priv_ok));

    state_d = state_q;
    if (!trace_activated_i) begin
      state_d = WIN_WAIT;
    end else if (advance) begin
      case (state_q)
        WIN_WAIT:   if (start_hit && !stop_hit) state_d = WIN_ACTIVE;
        WIN_ACTIVE: if (stop_hit)               state_d = WIN_WAIT;
        default:    state_d = WIN_WAIT;
      endcase
    end

    count_d = count_q;
    if (count_clear_i) begin
      count_d = '0;
    end else if (qual_d && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WIN_WAIT;
      qual_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      qual_q  <= qual_d;
      count_q <= count_d;
    end
  end

  assign trace_qualified_o = qual_q;
  assign window_active_o   = (state_q == WIN_ACTIVE);
  assign qual_count_o      = count_q;

endmodule

// File: tb/tb_trdb_filter_ranges.sv
// Directed + randomized bench for trdb_filter_ranges against a behavioural model of the qualifier.
module tb_trdb_filter_ranges;

  localparam int NR   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic act = 1'b0, apply = 1'b0, sel_priv = 1'b0, clear = 1'b0;
  logic [1:0] which = 2'd0;
  logic [NR-1:0][1:0]  mode = '0;
  logic [NR-1:0][31:0] lo   = '0;
  logic [NR-1:0][31:0] hi   = '0;
  logic          q_o, win_o;
  logic [CW-1:0] cnt_o;

  int ntests = 0;
  int nfail  = 0;

  // Reference model state
  bit m_q = 0, m_active = 0;
  int m_cnt = 0;

  trdb_filter_ranges_if #(.XLEN(32)) rif ();

  trdb_filter_ranges #(.NRANGES(NR), .XLEN(32), .CNT_W(CW)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .ret_if                (rif.slave),
    .trace_activated_i     (act),
    .apply_filters_i       (apply),
    .trace_selected_priv_i (sel_priv),
    .which_priv_i          (which),
    .range_mode_i          (mode),
    .range_lower_i         (lo),
    .range_higher_i        (hi),
    .count_clear_i         (clear),
    .trace_qualified_o     (q_o),
    .window_active_o       (win_o),
    .qual_count_o          (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of retirement, advance the model, then check all outputs.
  task automatic step(input bit v, input logic [31:0] a, input logic [1:0] p, input string tag);
    bit inc_any, inc_hit, st_any, st_hit, sp_hit, h, q;
    inc_any = 0; inc_hit = 0; st_any = 0; st_hit = 0; sp_hit = 0;
    rif.ivalid = v;
    rif.iaddr  = a;
    rif.priv   = p;
    for (int k = 0; k < NR; k++) begin
      h = (lo[k] <= a) && (a < hi[k]);
      if (mode[k] == 2'd1) begin inc_any = 1; inc_hit |= h; end
      if (mode[k] == 2'd2) begin st_any = 1; st_hit |= h; end
      if (mode[k] == 2'd3) sp_hit |= h;
    end
    q = v && act && (!apply || ((!inc_any || inc_hit) &&
                                (!st_any || m_active || st_hit) &&
                                (!sel_priv || p == which)));
    if (rst) begin
      m_q = 0; m_active = 0; m_cnt = 0;
    end else begin
      m_q = q;
      if (!act) m_active = 0;
      else if (v && apply) m_active = sp_hit ? 1'b0 : (st_hit ? 1'b1 : m_active);
      if (clear) m_cnt = 0;
      else if (q) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    end
    @(posedge clk);
    #1;
    check({tag, ".qual"},  32'(q_o),   32'(m_q));
    check({tag, ".win"},   32'(win_o), 32'(m_active));
    check({tag, ".count"}, 32'(cnt_o), 32'(m_cnt));
  endtask

  initial begin
    rif.ivalid = 1'b0;
    rif.iaddr  = '0;
    rif.priv   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.qual",  32'(q_o),   32'd0);
    check("reset.win",   32'(win_o), 32'd0);
    check("reset.count", 32'(cnt_o), 32'd0);

    // Unfiltered: every valid instruction qualifies
    rst = 1'b0; act = 1'b1; apply = 1'b0;
    for (int i = 0; i < 5; i++) step(1, 32'(i * 4), 2'd0, "nofilt");
    step(0, 32'h0, 2'd0, "nofilt_idle");
    check("nofilt.count5", 32'(cnt_o), 32'd5);
    clear = 1'b1; step(0, 32'h0, 2'd0, "clear"); clear = 1'b0;

    // Include range, then an empty range
    apply = 1'b1;
    mode[0] = 2'd1; lo[0] = 32'h1000; hi[0] = 32'h2000;
    step(1, 32'h0FFC, 2'd0, "inc_below");
    step(1, 32'h1000, 2'd0, "inc_lower");
    step(1, 32'h1FFC, 2'd0, "inc_top");
    step(1, 32'h2000, 2'd0, "inc_upper");
    hi[0] = 32'h1000;
    step(1, 32'h1000, 2'd0, "empty_a");
    step(1, 32'h0FFC, 2'd0, "empty_b");
    check("empty.noqual", 32'(q_o), 32'd0);

    // Start/stop window
    mode[0] = 2'd0;
    mode[1] = 2'd2; lo[1] = 32'h100; hi[1] = 32'h104;
    mode[2] = 2'd3; lo[2] = 32'h200; hi[2] = 32'h204;
    step(1, 32'h080, 2'd0, "win_pre");
    step(1, 32'h100, 2'd0, "win_start");
    check("win_start.active", 32'(win_o), 32'd1);
    step(1, 32'h180, 2'd0, "win_mid");
    step(1, 32'h200, 2'd0, "win_stop");
    step(1, 32'h280, 2'd0, "win_post");

    // Overlapping start+stop, back-to-back stop/start
    lo[1] = 32'h300; hi[1] = 32'h304;
    lo[2] = 32'h300; hi[2] = 32'h304;
    mode[3] = 2'd2; lo[3] = 32'h400; hi[3] = 32'h404;
    step(1, 32'h300, 2'd0, "both_wait");
    step(1, 32'h400, 2'd0, "enter");
    step(1, 32'h300, 2'd0, "both_active");
    step(1, 32'h400, 2'd0, "reenter");
    step(1, 32'h300, 2'd0, "stop_b2b");
    step(1, 32'h400, 2'd0, "start_b2b");
    check("b2b.active", 32'(win_o), 32'd1);

    // Privilege match, then deactivate while ACTIVE
    mode[1] = 2'd0; mode[2] = 2'd0;
    sel_priv = 1'b1; which = 2'd3;
    for (int i = 0; i < 4; i++) step(1, 32'h500, (i % 2 == 0) ? 2'd0 : 2'd3, "priv");
    step(1, 32'h400, 2'd3, "priv_start");
    act = 1'b0;
    step(0, 32'h0, 2'd3, "deact");
    check("deact.win", 32'(win_o), 32'd0);

    // Saturation and clear-priority
    act = 1'b1; sel_priv = 1'b0; mode = '0;
    for (int i = 0; i < 20; i++) step(1, 32'(i * 4), 2'd0, "sat");
    check("sat.count15", 32'(cnt_o), 32'd15);
    clear = 1'b1; step(1, 32'h10, 2'd0, "clear_qual"); clear = 1'b0;

    // Reset mid-window
    mode[3] = 2'd2;
    step(1, 32'h400, 2'd0, "pre_rst");
    rst = 1'b1; step(1, 32'h404, 2'd0, "mid_rst"); rst = 1'b0;

    // Randomized configurations, changed only while deactivated
    for (int r = 0; r < 10; r++) begin
      act = 1'b0; clear = 1'b0;
      step(0, 32'h0, 2'd0, "rnd_cfg");
      for (int k = 0; k < NR; k++) begin
        mode[k] = 2'($urandom_range(0, 3));
        lo[k]   = 32'($urandom_range(0, 32'h3F0)) & ~32'h3;
        hi[k]   = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 32'h400))
                                               : lo[k] + 32'($urandom_range(0, 32'h80));
      end
      apply    = ($urandom_range(0, 3) != 0);
      sel_priv = 1'($urandom_range(0, 1));
      which    = 2'($urandom_range(0, 3));
      act      = 1'b1;
      for (int i = 0; i < 30; i++) begin
        clear = ($urandom_range(0, 15) == 0);
        step($urandom_range(0, 3) != 0, 32'($urandom_range(0, 32'h40F)) & ~32'h3,
             2'($urandom_range(0, 3)), "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
